// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions used by the predictor table RAMs.
package bp_pkg;
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;
endpackage

// File: rtl/sdp_ram_core.sv
// Reset-free simple-dual-port storage: one write port and one registered read port,
// kept free of resets so it maps onto block RAM.
module sdp_ram_core #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 2
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Read and write share one process so a same-address access returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sdp_ram_clr.sv
// Predictor table RAM with a hardware clear sweep, read-valid tracking,
// optional write-to-read bypass and an optional output register.
module sdp_ram_clr
    import bp_pkg::*;
#(
    parameter int                    num_entries = 512,
    parameter int                    addr_width  = $clog2(num_entries),
    parameter int                    data_width  = 2,
    parameter logic [data_width-1:0] init_value  = '0,
    parameter bit                    bypass      = 1'b1,
    parameter bit                    out_reg     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  ready,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] q,
    output logic                  q_valid
);
    localparam logic [addr_width-1:0] LAST = addr_width'(num_entries - 1);

    ram_state_e            r_state;
    logic [addr_width-1:0] r_cnt;
    logic                  r_vld1;
    logic                  r_byp_hit;
    logic [data_width-1:0] r_byp_data;

    logic                  w_clearing;
    logic                  w_rd;
    logic                  w_wr_user;
    logic                  w_core_we;
    logic [addr_width-1:0] w_core_waddr;
    logic [data_width-1:0] w_core_wdata;
    logic [data_width-1:0] w_rdata;
    logic [data_width-1:0] w_s1_data;

    assign w_clearing = (r_state == CLEAR);
    assign w_rd       = ~w_clearing & re;
    assign w_wr_user  = ~w_clearing & we;
    assign ready      = (r_state == READY);

    // The sweep owns the write port while clearing; user traffic is dropped, not queued.
    assign w_core_we    = w_clearing | w_wr_user;
    assign w_core_waddr = w_clearing ? r_cnt : waddr;
    assign w_core_wdata = w_clearing ? init_value : wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_cnt == LAST) r_state <= READY;
                    else               r_cnt   <= r_cnt + 1'b1;
                end
                default: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    sdp_ram_core #(
        .DEPTH (num_entries),
        .AW    (addr_width),
        .DW    (data_width)
    ) u_core (
        .i_clk   (clk),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_re    (w_rd),
        .i_raddr (raddr),
        .o_rdata (w_rdata)
    );

    // Collision is captured alongside the read so the forwarded word lines up with o_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld1     <= 1'b0;
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_vld1 <= w_rd;
            if (w_rd) begin
                r_byp_hit  <= bypass && w_wr_user && (waddr == raddr);
                r_byp_data <= wdata;
            end
        end
    end

    assign w_s1_data = r_byp_hit ? r_byp_data : w_rdata;

    generate
        if (out_reg) begin : g_oreg
            logic [data_width-1:0] r_q;
            logic                  r_qv;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q  <= '0;
                    r_qv <= 1'b0;
                end else begin
                    r_qv <= r_vld1;
                    if (r_vld1) r_q <= w_s1_data;
                end
            end

            assign q       = r_q;
            assign q_valid = r_qv;
        end else begin : g_noreg
            // The core output cannot be reset, so q reads as zero until the first read lands.
            logic r_have;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)       r_have <= 1'b0;
                else if (w_rd) r_have <= 1'b1;
            end

            assign q       = r_have ? w_s1_data : '0;
            assign q_valid = r_vld1;
        end
    endgenerate
endmodule

// File: tb/tb_sdp_ram_clr.sv
// Bench for sdp_ram_clr: three instances (bypass/latency-1, no-bypass/latency-2,
// 12-entry) driven together and compared against a per-instance array model.
module tb_sdp_ram_clr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, clr_req = 1'b0, we = 1'b0, re = 1'b0;
    logic [3:0] waddr = '0, raddr = '0;
    logic [7:0] wdata = '0;
    logic       we_c, re_c;
    assign we_c = we && (waddr < 4'd12);
    assign re_c = re && (raddr < 4'd12);

    logic [7:0] q0, q1, q2;
    logic       qv0, qv1, qv2, rd0, rd1, rd2;
    logic [7:0] q_o [3];
    logic       qv_o [3];
    logic       rdy_o [3];
    assign q_o[0] = q0;   assign q_o[1] = q1;   assign q_o[2] = q2;
    assign qv_o[0] = qv0; assign qv_o[1] = qv1; assign qv_o[2] = qv2;
    assign rdy_o[0] = rd0; assign rdy_o[1] = rd1; assign rdy_o[2] = rd2;

    sdp_ram_clr #(.num_entries(16), .data_width(8), .init_value(8'h5A), .bypass(1'b1), .out_reg(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rd0), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .q(q0), .q_valid(qv0));
    sdp_ram_clr #(.num_entries(16), .data_width(8), .init_value(8'h5A), .bypass(1'b0), .out_reg(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rd1), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .q(q1), .q_valid(qv1));
    sdp_ram_clr #(.num_entries(12), .data_width(8), .init_value(8'h5A), .bypass(1'b1), .out_reg(1'b0)) dut_c (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rd2), .we(we_c), .waddr(waddr), .wdata(wdata),
        .re(re_c), .raddr(raddr), .q(q2), .q_valid(qv2));

    localparam int NE  [3] = '{16, 16, 12};
    localparam int LAT [3] = '{1, 2, 1};
    localparam bit BYP [3] = '{1'b1, 1'b0, 1'b1};

    logic [7:0] m_mem [3][16];
    int         m_left [3];
    int         m_ca [3];
    logic       m_dv [3];
    logic [7:0] m_dd [3];
    logic [7:0] m_q [3];
    logic       m_qv [3];

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = NE[k];
            m_ca[k]   = 0;
            m_dv[k]   = 1'b0;
            m_q[k]    = 8'h00;
            m_qv[k]   = 1'b0;
        end
    endtask

    // One rising edge of behaviour: a table either still has clear writes owed or serves traffic.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic       kwe, kre, nv;
            logic [7:0] nd;
            kwe = (k == 2) ? we_c : we;
            kre = (k == 2) ? re_c : re;
            nv  = (m_left[k] == 0) && kre;
            nd  = (BYP[k] && kwe && waddr == raddr) ? wdata : m_mem[k][raddr];
            if (LAT[k] == 1) begin
                m_qv[k] = nv;
                if (nv) m_q[k] = nd;
            end else begin
                m_qv[k] = m_dv[k];
                if (m_dv[k]) m_q[k] = m_dd[k];
                m_dv[k] = nv;
                if (nv) m_dd[k] = nd;
            end
            if (m_left[k] != 0) begin
                m_mem[k][m_ca[k]] = 8'h5A;
                m_ca[k]++;
                m_left[k]--;
            end else begin
                if (kwe) m_mem[k][waddr] = wdata;
                if (clr_req) begin
                    m_left[k] = NE[k];
                    m_ca[k]   = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                         input logic r, input logic [3:0] ra, input logic c);
        we = w; waddr = wa; wdata = wd; re = r; raddr = ra; clr_req = c;
    endtask

    // The 12-entry instance must never see a sweep or user write beyond its depth.
    always @(negedge clk) begin
        if (dut_c.u_core.i_we) begin
            total++;
            if (dut_c.u_core.i_waddr >= 4'd12) begin
                bad++;
                $display("FAIL c_waddr_range got=%0d limit=11 @%0t", dut_c.u_core.i_waddr, $time);
            end
        end
    end

    task automatic test_reset();
        int rise [3];
        rise = '{-1, -1, -1};
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy_o[k] !== 1'b0 || qv_o[k] !== 1'b0 || q_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL reset_state[%0d] got=%b/%b/%h exp=0/0/00", k, rdy_o[k], qv_o[k], q_o[k]);
            end
        end
        repeat (3) cyc();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            for (int k = 0; k < 3; k++) begin
                if (rdy_o[k] === 1'b1 && rise[k] < 0) rise[k] = i;
                total++;
                if (rdy_o[k] !== (m_left[k] == 0)) begin
                    bad++;
                    $display("FAIL rst_ready[%0d] cyc=%0d got=%b exp=%b", k, i, rdy_o[k], m_left[k] == 0);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rise[k] != NE[k]) begin
                bad++;
                $display("FAIL rst_clear_len[%0d] got=%0d exp=%0d", k, rise[k], NE[k]);
            end
        end
    endtask

    task automatic test_init_read();
        int pulses [3];
        pulses = '{0, 0, 0};
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
            else        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
            cyc();
            for (int k = 0; k < 3; k++) begin
                if (qv_o[k] === 1'b1) pulses[k]++;
                total++;
                if (qv_o[k] !== m_qv[k] || q_o[k] !== m_q[k]) begin
                    bad++;
                    $display("FAIL init_read[%0d] got=%b/%h exp=%b/%h", k, qv_o[k], q_o[k], m_qv[k], m_q[k]);
                end
                total++;
                if (qv_o[k] === 1'b1 && q_o[k] !== 8'h5A) begin
                    bad++;
                    $display("FAIL init_value[%0d] got=%h exp=5a", k, q_o[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pulses[k] != NE[k]) begin
                bad++;
                $display("FAIL init_pulses[%0d] got=%0d exp=%0d", k, pulses[k], NE[k]);
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 4'd5, 8'hC3, 1'b0, 4'd0, 1'b0);
        cyc();
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);
        cyc();
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
        total++;
        if (qv_o[0] !== 1'b1 || q_o[0] !== 8'hC3) begin
            bad++;
            $display("FAIL wr_rd_lat1 got=%b/%h exp=1/c3", qv_o[0], q_o[0]);
        end
        total++;
        if (qv_o[1] !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd_lat2_early got=%b exp=0", qv_o[1]);
        end
        cyc();
        total++;
        if (qv_o[1] !== 1'b1 || q_o[1] !== 8'hC3) begin
            bad++;
            $display("FAIL wr_rd_lat2 got=%b/%h exp=1/c3", qv_o[1], q_o[1]);
        end
        total++;
        if (qv_o[0] !== 1'b0 || q_o[0] !== 8'hC3) begin
            bad++;
            $display("FAIL wr_rd_hold got=%b/%h exp=0/c3", qv_o[0], q_o[0]);
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 4'd7, 8'h11, 1'b1, 4'd7, 1'b0);
        cyc();
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
        total++;
        if (qv_o[0] !== 1'b1 || q_o[0] !== 8'h11) begin
            bad++;
            $display("FAIL collide_bypass got=%b/%h exp=1/11", qv_o[0], q_o[0]);
        end
        total++;
        if (qv_o[2] !== 1'b1 || q_o[2] !== 8'h11) begin
            bad++;
            $display("FAIL collide_bypass_c got=%b/%h exp=1/11", qv_o[2], q_o[2]);
        end
        cyc();
        total++;
        if (qv_o[1] !== 1'b1 || q_o[1] !== 8'h5A) begin
            bad++;
            $display("FAIL collide_old got=%b/%h exp=1/5a", qv_o[1], q_o[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 49) == 0));
            cyc();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (rdy_o[k] !== (m_left[k] == 0) || qv_o[k] !== m_qv[k] || q_o[k] !== m_q[k]) begin
                    bad++;
                    $display("FAIL random[%0d] i=%0d got=%b/%b/%h exp=%b/%b/%h", k, i,
                             rdy_o[k], qv_o[k], q_o[k], m_left[k] == 0, m_qv[k], m_q[k]);
                end
            end
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
        repeat (20) cyc();
    endtask

    task automatic test_reclear();
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'(a), 8'hFF, 1'b0, 4'd0, 1'b0);
            cyc();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1);
        cyc();
        total++;
        if (qv_o[0] !== 1'b1 || q_o[0] !== 8'hFF || rdy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL reclear_read got=%b/%h rdy=%b exp=1/ff rdy=0", qv_o[0], q_o[0], rdy_o[0]);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'b0);
            cyc();
            total++;
            if (rdy_o[0] !== (i == 16) || rdy_o[1] !== (i == 16)) begin
                bad++;
                $display("FAIL reclear_ready i=%0d got=%b%b exp=%b", i, rdy_o[0], rdy_o[1], i == 16);
            end
            total++;
            if (qv_o[0] !== 1'b0 || qv_o[1] !== (i == 1) || (i == 1 && q_o[1] !== 8'hFF)) begin
                bad++;
                $display("FAIL reclear_qv i=%0d got=%b/%b/%h exp=0/%b/ff", i, qv_o[0], qv_o[1], q_o[1], i == 1);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (qv_o[k] !== m_qv[k] || q_o[k] !== m_q[k]) begin
                    bad++;
                    $display("FAIL reclear_model[%0d] got=%b/%h exp=%b/%h", k, qv_o[k], q_o[k], m_qv[k], m_q[k]);
                end
            end
        end
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
            else        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
            cyc();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (qv_o[k] !== m_qv[k] || (qv_o[k] === 1'b1 && q_o[k] !== 8'h5A)) begin
                    bad++;
                    $display("FAIL reclear_after[%0d] got=%b/%h exp=%b/5a", k, qv_o[k], q_o[k], m_qv[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int rise;
        rise = -1;
        for (int a = 10; a < 16; a++) begin
            drive(1'b1, 4'(a), 8'h77, 1'b0, 4'd0, 1'b0);
            cyc();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd12, 1'b1);
        cyc();
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
        repeat (9) cyc();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy_o[k] !== 1'b0 || qv_o[k] !== 1'b0 || q_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL midrst_async[%0d] got=%b/%b/%h exp=0/0/00", k, rdy_o[k], qv_o[k], q_o[k]);
            end
        end
        cyc();
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            if (rdy_o[0] === 1'b1 && rise < 0) rise = i;
        end
        total++;
        if (rise != 16) begin
            bad++;
            $display("FAIL midrst_clear_len got=%0d exp=16", rise);
        end
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
            else        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
            cyc();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (qv_o[k] !== m_qv[k] || (qv_o[k] === 1'b1 && q_o[k] !== 8'h5A)) begin
                    bad++;
                    $display("FAIL midrst_after[%0d] got=%b/%h exp=%b/5a", k, qv_o[k], q_o[k], m_qv[k]);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_read();
        test_write_read();
        test_collision();
        test_random();
        test_reclear();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdp_ram_clr.md
# sdp_ram_clr

Parametrised simple-dual-port RAM that succeeds the fixed 2-bit predictor table RAM. It adds an asynchronous reset, and a hardware clear engine that sweeps every entry to a programmable init value after reset or on request. It also adds read-enable with a valid flag, optional same-address write-to-read bypass, and an optional output pipeline register. It backs the TAGE base/tagged tables and other branch-predictor state that must be flushed without a `$readmem` image.

## Interface
- `num_entries`, 512, table depth; any value ≥ 2, not required to be a power of two
- `addr_width`, `$clog2(num_entries)`, address width
- `data_width`, 2, entry width
- `init_value`, `'0`, `data_width`-bit value written to every entry by the clear sweep
- `bypass`, 1, 1 = a same-cycle write to the read address forwards `wdata`; 0 = the read returns old data
- `out_reg`, 0, 1 = an extra output register stage is added, giving read latency 2
- `clk` input 1: the single clock; all state updates on the rising edge
- `rst` input 1: asynchronous, active-high reset (already decided); one clock, and reset is asynchronous and active-high
- `clr_req` input 1: pulse requests a full re-clear of the table
- `ready` output 1: high when the table accepts reads and writes; low while clearing
- `we` input 1: write enable
- `waddr` input `addr_width`: write address
- `wdata` input `data_width`: write data
- `re` input 1: read enable
- `raddr` input `addr_width`: read address
- `q` output `data_width`: read data
- `q_valid` output 1: `q` holds the result of an accepted read

## Operation
- FSM states: CLEAR and READY.
  - `rst` asserted: state goes to CLEAR, clear counter to 0, `ready`=0, `q`=0, `q_valid`=0, and all pipeline valids to 0, all asynchronously.
  - The storage array is not reset; it is initialised only by the sweep.
- CLEAR:
  - Each cycle, `init_value` is written to address = counter, and the counter increments.
  - At counter = `num_entries`-1 the final write occurs and the next state is READY.
  - `we`, `re` and `clr_req` are ignored; they are not queued.
- READY:
  - `ready`=1.
  - `we`=1: `mem[waddr]` ← `wdata`.
  - `re`=1: read `raddr`.
  - `clr_req`=1: counter ← 0 and next state CLEAR. A `we`/`re` in the same cycle is still performed.
- Read-during-write to the same address (READY, `we` & `re`, `waddr`==`raddr`):
  - `bypass`=1: the read returns `wdata`.
  - `bypass`=0: the read returns the prior contents.
- Reads accepted before entering CLEAR complete normally through the pipeline, including the final stage, and return pre-clear data.
- `q` holds its last value when no read completes. `q_valid` is a one-cycle pulse per completed read.
- The counter is `addr_width` bits wide. Termination compares against `num_entries`-1, so a non-power-of-two depth never writes out of range.

## Timing
- Read latency: `out_reg`=0 means `q`/`q_valid` are valid 1 cycle after `re`; `out_reg`=1 means 2 cycles.
- Sustained throughput in READY is one read and one write per cycle.
- Clear duration is exactly `num_entries` cycles.
  - After `rst` deasserts, CLEAR writes occur on the first `num_entries` rising edges.
  - `ready` rises on the edge after the last CLEAR write.
- After a `clr_req` accepted in cycle t, `ready`=0 from t+1 through t+`num_entries`, and `ready`=1 at t+`num_entries`+1.
- Reset mid-sweep restarts the sweep from address 0.
- `ready` is registered and never depends combinationally on the inputs.

## Structure
- Shared package `bp_pkg`: `ram_state_e` {CLEAR, READY}.
- Sub-module `sdp_ram_core`: a reset-free array with one write port and one synchronous read port, so that it is inferred as block RAM.
- The wrapper holds the following logic:
  - the FSM and counter
  - the write-port mux between sweep and user writes
  - the bypass compare and data mux
  - the optional output stage and valid pipeline

## Test plan
Parameters for all scenarios: `num_entries`=16, `data_width`=8, `init_value`=8'h5A.
- Reset release: `ready`=0 for 16 cycles and rises on cycle 17. Reading all 16 addresses then returns 8'h5A, with `q_valid` pulsed once per read.
- Write then read: write 8'hC3 to addr 5, read addr 5 the next cycle. `q`=8'hC3 after 1 cycle with `out_reg`=0, or after 2 cycles with `out_reg`=1.
- Same-address collision: `we`, `re` with addr 7 and `wdata`=8'h11, old value 8'h5A. `q`=8'h11 with `bypass`=1 and 8'h5A with `bypass`=0.
- Re-clear:
  - Fill all entries with 8'hFF, then pulse `clr_req` together with `re`@3.
  - The read returns 8'hFF.
  - `ready` is low for 16 cycles; `we`/`re` issued during this window produce no `q_valid` and no writes.
  - After the sweep, every entry reads 8'h5A.
- Mid-sweep reset: assert `rst` at sweep address 9. `q_valid`/`ready` go to 0 immediately and the sweep restarts at 0, giving a full 16-cycle CLEAR.
- Non-power-of-two depth (`num_entries`=12): the clear takes 12 cycles, and no write address ≥ 12 is ever driven to `sdp_ram_core`, checked by an assertion.
